// File: rtl/led_fade_driver.sv
// led_fade_driver
//
// Turns an 8-bit on/off chaser pattern into eight PWM-driven LED outputs
// with a "comet-tail" afterglow. A bit that turns on drives its LED at full
// brightness immediately; a bit that turns off fades to dark in fixed steps
// at a slow decay rate instead of snapping off.
//
// Optional feature macro: LED_FADE_GAMMA_EN
//   defined   -> PWM compare uses an approximate gamma-2 curve (b*b >> PWM_BITS),
//                with full brightness forced to stay always-on.
//   undefined -> linear response (PWM compare uses b directly).
//
// Parameters:
//   PWM_BITS   brightness / PWM resolution; MAX = 2**PWM_BITS - 1
//   DECAY_DIV  clock cycles between decay ticks (>= 2)
//   DECAY_STEP brightness decrement per decay tick (1..MAX)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     1 = run; 0 = blank all outputs and clear every channel
//   led_in     chaser pattern from the upstream stage
//   led_out    registered PWM drive to the LED pins
//   busy       registered; 1 while any channel brightness is nonzero
//   chan_state debug view of the per-channel FSMs, 2 bits per channel
//              (channel i at [2i+1:2i]; 0 = OFF, 1 = ON, 2 = FADE)

module led_fade_driver #(
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 50000,
    parameter int DECAY_STEP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  led_in,
    output logic [7:0]  led_out,
    output logic        busy,
    output logic [15:0] chan_state
);

    localparam int DW = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;

    localparam logic [PWM_BITS-1:0] B_MAX     = '1;
    localparam logic [PWM_BITS-1:0] B_STEP    = PWM_BITS'(DECAY_STEP);
    localparam logic [PWM_BITS-1:0] PCNT_LAST = B_MAX - PWM_BITS'(1);
    localparam logic [DW-1:0]       DCNT_LAST = DW'(DECAY_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_FADE = 2'd2
    } chan_state_t;

    logic [7:0]          in_q;
    logic [DW-1:0]       dcnt;
    logic [PWM_BITS-1:0] pcnt;
    logic                tick;

    chan_state_t         st    [8];
    chan_state_t         nx_st [8];
    logic [PWM_BITS-1:0] b     [8];
    logic [PWM_BITS-1:0] nx_b  [8];

    // Brightness actually compared against the PWM counter.
    function automatic logic [PWM_BITS-1:0] b_eff(input logic [PWM_BITS-1:0] bv);
`ifdef LED_FADE_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, bv} * {{PWM_BITS{1'b0}}, bv};
        // Full-on must stay always-on; the squared value alone would land
        // just under MAX and leave a one-cycle gap per PWM period.
        if (bv == B_MAX) begin
            return B_MAX;
        end
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return bv;
`endif
    endfunction

    assign tick = (dcnt == DCNT_LAST);

    // Shared counters, input register and output registers. The counters
    // free-run regardless of pattern activity, so the first decay step of
    // a fade lands anywhere from 1 to DECAY_DIV cycles after it starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            dcnt    <= '0;
            pcnt    <= '0;
            led_out <= '0;
            busy    <= 1'b0;
        end else begin
            in_q <= led_in;
            if (!enable) begin
                dcnt    <= '0;
                pcnt    <= '0;
                led_out <= '0;
                busy    <= 1'b0;
            end else begin
                dcnt <= tick ? '0 : dcnt + DW'(1);
                pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + PWM_BITS'(1);
                busy <= 1'b0;
                for (int i = 0; i < 8; i++) begin
                    led_out[i] <= (pcnt < b_eff(b[i]));
                    if (b[i] != '0) begin
                        busy <= 1'b1;
                    end
                end
            end
        end
    end

    // Per-channel FSM state and brightness registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                st[i] <= ST_OFF;
                b[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                st[i] <= nx_st[i];
                b[i]  <= nx_b[i];
            end
        end
    end

    // Per-channel next state. All eight channels evaluate independently.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            nx_st[i] = st[i];
            nx_b[i]  = b[i];
            if (!enable) begin
                nx_st[i] = ST_OFF;
                nx_b[i]  = '0;
            end else begin
                case (st[i])
                    ST_OFF: begin
                        if (in_q[i]) begin
                            nx_st[i] = ST_ON;
                            nx_b[i]  = B_MAX;
                        end
                    end
                    ST_ON: begin
                        if (!in_q[i]) begin
                            nx_st[i] = ST_FADE;
                        end
                    end
                    ST_FADE: begin
                        // Retrigger wins over a decay tick in the same cycle.
                        if (in_q[i]) begin
                            nx_st[i] = ST_ON;
                            nx_b[i]  = B_MAX;
                        end else if (tick) begin
                            if (b[i] > B_STEP) begin
                                nx_b[i] = b[i] - B_STEP;
                            end else begin
                                nx_b[i]  = '0;
                                nx_st[i] = ST_OFF;
                            end
                        end
                    end
                    default: begin
                        nx_st[i] = ST_OFF;
                        nx_b[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        chan_state = '0;
        for (int i = 0; i < 8; i++) begin
            chan_state[2*i +: 2] = st[i];
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver (PWM_BITS=4, DECAY_DIV=30,
// DECAY_STEP=5). A behavioural model of the channel behaviour pushes the
// expected {busy, led_out} into exp_q at every clock edge; the checker pops
// and compares on the falling edge. Directed checks cover reset latency,
// steady-on, fade duty/timing, retrigger priority, enable and async reset.
// Define LED_FADE_GAMMA_EN to build and check the gamma variant.

module tb_led_fade_driver;

    localparam int PWM_BITS = 4;
    localparam int MAXV     = 15;
    localparam int DDIV     = 30;
    localparam int DSTEP    = 5;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  led_in;
    logic [7:0]  led_out;
    logic        busy;
    logic [15:0] chan_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0] exp_q[$];

    led_fade_driver #(
        .PWM_BITS   (PWM_BITS),
        .DECAY_DIV  (DDIV),
        .DECAY_STEP (DSTEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .led_in     (led_in),
        .led_out    (led_out),
        .busy       (busy),
        .chan_state (chan_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking task ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_in_q;
    int         m_dcnt, m_pcnt;
    int         m_b  [8];
    int         m_st [8];   // 0 off, 1 on, 2 fade

    logic [7:0] nx_in_q;
    int         nx_dcnt, nx_pcnt;
    int         nx_b  [8];
    int         nx_st [8];
    logic [7:0] nx_led;
    logic       nx_busy;
    logic       m_tick;

    function automatic int beff(input int bv);
`ifdef LED_FADE_GAMMA_EN
        if (bv == MAXV) return MAXV;
        return (bv * bv) / (MAXV + 1);
`else
        return bv;
`endif
    endfunction

    always_comb begin
        nx_in_q = led_in;
        m_tick  = (m_dcnt == DDIV - 1);
        nx_dcnt = 0;
        nx_pcnt = 0;
        nx_led  = 8'h00;
        nx_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nx_b[i]  = 0;
            nx_st[i] = 0;
        end
        if (enable) begin
            nx_dcnt = m_tick ? 0 : m_dcnt + 1;
            nx_pcnt = (m_pcnt == MAXV - 1) ? 0 : m_pcnt + 1;
            for (int i = 0; i < 8; i++) begin
                nx_b[i]   = m_b[i];
                nx_st[i]  = m_st[i];
                nx_led[i] = (m_pcnt < beff(m_b[i]));
                if (m_b[i] != 0) nx_busy = 1'b1;
                if (m_st[i] == 0) begin
                    if (m_in_q[i]) begin nx_st[i] = 1; nx_b[i] = MAXV; end
                end else if (m_st[i] == 1) begin
                    if (!m_in_q[i]) nx_st[i] = 2;
                end else begin
                    if (m_in_q[i]) begin
                        nx_st[i] = 1; nx_b[i] = MAXV;
                    end else if (m_tick) begin
                        if (m_b[i] > DSTEP) nx_b[i] = m_b[i] - DSTEP;
                        else begin nx_b[i] = 0; nx_st[i] = 0; end
                    end
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_q <= 8'h00;
            m_dcnt <= 0;
            m_pcnt <= 0;
            for (int i = 0; i < 8; i++) begin
                m_b[i]  <= 0;
                m_st[i] <= 0;
            end
            exp_q.delete();
        end else begin
            exp_q.push_back({nx_busy, nx_led});
            m_in_q <= nx_in_q;
            m_dcnt <= nx_dcnt;
            m_pcnt <= nx_pcnt;
            for (int i = 0; i < 8; i++) begin
                m_b[i]  <= nx_b[i];
                m_st[i] <= nx_st[i];
            end
        end
    end

    // ---------------- scoreboard checker ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            check("in_reset", {23'd0, busy, led_out}, 32'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", {23'd0, busy, led_out}, {23'd0, e});
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_b0(input int val, input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (m_b[0] == val) ok = 1'b1;
        end
        if (!ok) check(tag, 32'd0, 32'd1);
    endtask

    task automatic count_duty(output int n);
        n = 0;
        repeat (MAXV) begin
            @(negedge clk);
            n += int'(led_out[0]);
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] pat);
        @(negedge clk);
        enable = en;
        led_in = pat;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, on0, hi, bsy, t10, t5, t0;
        bit found;

        rst_n  = 1'b0;
        enable = 1'b1;
        led_in = 8'hFF;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset release: full-on shows from the 3rd edge.
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_edge2", {24'd0, led_out}, 32'h00);
        @(negedge clk);
        check("rst_edge3", {24'd0, led_out}, 32'hFF);

        // Clear via enable, then steady on for bit 0.
        drive(1'b0, 8'h01);
        @(negedge clk);
        check("en_clear", {23'd0, busy, led_out}, 32'd0);
        check("en_clear_st", {16'd0, chan_state}, 32'd0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        on0 = 0; hi = 0; bsy = 0;
        repeat (45) begin
            @(negedge clk);
            on0 += int'(led_out[0]);
            hi  += int'(led_out[7:1] != 7'd0);
            bsy += int'(busy);
        end
        check("steady_on0", on0, 45);
        check("steady_hi", hi, 0);
        check("steady_busy", bsy, 45);

        // Fade 15 -> 10 -> 5 -> 0.
        drive(1'b1, 8'h00);
        wait_b0(10, "fade_to10_timeout");
        t10 = cyc;
        count_duty(n);
        check("duty10", n, 10);
        wait_b0(5, "fade_to5_timeout");
        t5 = cyc;
        check("tick_gap_10_5", t5 - t10, DDIV);
        count_duty(n);
        check("duty5", n, 5);
        wait_b0(0, "fade_to0_timeout");
        t0 = cyc;
        check("tick_gap_5_0", t0 - t5, DDIV);
        check("busy_lag", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("busy_fall", {31'd0, busy}, 32'd0);
        count_duty(n);
        check("duty0", n, 0);

        // Retrigger coincident with a decay tick while b = 5.
        drive(1'b1, 8'h01);
        wait_b0(MAXV, "retrig_on_timeout");
        drive(1'b1, 8'h00);
        wait_b0(5, "retrig_to5_timeout");
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (m_dcnt == DDIV - 2) found = 1'b1;
            else @(negedge clk);
        end
        check("retrig_align", {31'd0, found}, 32'd1);
        led_in = 8'h01;          // captured next edge, tick on the edge after
        @(negedge clk);
        check("retrig_pre_st", {30'd0, chan_state[1:0]}, 32'd2);
        @(negedge clk);
        check("retrig_state", {30'd0, chan_state[1:0]}, 32'd1);
        count_duty(n);
        check("retrig_duty", n, 15);

        // enable = 0 mid-fade.
        drive(1'b1, 8'h00);
        wait_b0(10, "enmid_timeout");
        enable = 1'b0;
        @(negedge clk);
        check("en_mid", {23'd0, busy, led_out}, 32'd0);
        check("en_mid_st", {16'd0, chan_state}, 32'd0);
        enable = 1'b1;

        // Asynchronous reset mid-fade.
        drive(1'b1, 8'h01);
        wait_b0(MAXV, "arst_on_timeout");
        drive(1'b1, 8'h00);
        wait_b0(10, "arst_fade_timeout");
        check("arst_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {23'd0, busy, led_out}, 32'd0);
        check("rst_async_st", {16'd0, chan_state}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef LED_FADE_GAMMA_EN
        drive(1'b1, 8'h01);
        wait_b0(MAXV, "gamma_on_timeout");
        count_duty(n);
        check("gamma_duty15", n, 15);
        drive(1'b1, 8'h00);
        wait_b0(10, "gamma_fade_timeout");
        count_duty(n);
        check("gamma_duty10", n, 6);
`endif

        // Random pattern soak, checked by the scoreboard.
        repeat (200) begin
            drive(($urandom_range(0, 19) != 0), 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
